// File: rtl/median_pkg.sv
// Shared definitions for the median filter: default pixel width and the
// 3x3 window slot numbering used by the window generator and the sorter.
package median_pkg;

  // Default pixel width in bits (unsigned pixels).
  localparam int DEF_DATA_W = 8;

  // Window slot indices, k = 3*row + col, row 0 = oldest line, col 2 = newest column.
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  // Number of pixels in one window.
  localparam int WIN_SLOTS = 9;

endpackage

// File: rtl/median_line_buffer.sv
// One image line of storage with a single shared address: the read returns
// the value stored before this cycle's write, so a line can be recirculated
// into the next buffer in the same cycle it is overwritten.
module median_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Combinational read, so the caller sees the pre-write contents.
  always_comb begin
    rd_data = mem[addr];
  end

  // Storage is deliberately not reset; rows are rewritten before they are used.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/median_window_3x3.sv
// Builds a 3x3 neighbourhood from a raster pixel stream using two line
// buffers and a 3x3 shift matrix; one window per interior pixel position.
module median_window_3x3
  import median_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic [DATA_W-1:0]             pix_in,
  input  logic                          sof,
  output logic [WIN_SLOTS*DATA_W-1:0]   win,
  output logic                          win_valid,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]     colCnt;
  logic [RW-1:0]     rowCnt;
  logic [CW-1:0]     curCol;
  logic [RW-1:0]     curRow;
  logic              interior;
  logic              lastPix;
  logic [DATA_W-1:0] lb0Rd;
  logic [DATA_W-1:0] lb1Rd;
  logic [DATA_W-1:0] newCol [3];
  logic [DATA_W-1:0] shReg  [3][3];
  logic [DATA_W-1:0] shNext [3][3];
  logic [WIN_SLOTS*DATA_W-1:0] winNext;

  // Position of the pixel on the input this cycle; sof forces it to the frame origin.
  always_comb begin
    curCol   = sof ? '0 : colCnt;
    curRow   = sof ? '0 : rowCnt;
    interior = (curRow >= RW'(2)) && (curCol >= CW'(2));
    lastPix  = (curRow == ROW_LAST) && (curCol == COL_LAST);
  end

  // LB1 holds line r-1 and receives the live pixel.
  median_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_W)
  ) u_lb1 (
    .clk     (clk),
    .we      (pix_valid),
    .addr    (curCol),
    .wr_data (pix_in),
    .rd_data (lb1Rd)
  );

  // LB0 holds line r-2 and receives what LB1 is about to lose.
  median_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_W)
  ) u_lb0 (
    .clk     (clk),
    .we      (pix_valid),
    .addr    (curCol),
    .wr_data (lb1Rd),
    .rd_data (lb0Rd)
  );

  // Next state of the shift matrix: every row moves left and takes the new column.
  always_comb begin
    newCol[0] = lb0Rd;
    newCol[1] = lb1Rd;
    newCol[2] = pix_in;
    for (int r = 0; r < 3; r++) begin
      shNext[r][0] = shReg[r][1];
      shNext[r][1] = shReg[r][2];
      shNext[r][2] = newCol[r];
    end
  end

  // Flatten the shifted matrix into slot order k = 3*row + col.
  always_comb begin
    winNext = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        winNext[(3*r + c)*DATA_W +: DATA_W] = shNext[r][c];
      end
    end
  end

  // Column/row counters advance per accepted pixel and wrap into the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colCnt <= '0;
      rowCnt <= '0;
    end else if (pix_valid) begin
      if (curCol == COL_LAST) begin
        colCnt <= '0;
        rowCnt <= (curRow == ROW_LAST) ? '0 : curRow + RW'(1);
      end else begin
        colCnt <= curCol + CW'(1);
        rowCnt <= curRow;
      end
    end
  end

  // Shift matrix moves on every accepted pixel, including border positions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          shReg[r][c] <= '0;
        end
      end
    end else if (pix_valid) begin
      shReg <= shNext;
    end
  end

  // Output registers: publish a window only for interior positions, hold it otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= pix_valid && interior;
      frame_done <= pix_valid && lastPix;
      if (pix_valid && interior) begin
        win <= winNext;
      end
    end
  end

endmodule

// File: tb/tb_median_window_3x3.sv
// Self-checking bench for median_window_3x3: a 4x4 instance checked every
// cycle against a frame-array model, plus a 3x3 instance for the minimum size.
module tb_median_window_3x3;
  import median_pkg::*;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  localparam logic [71:0] S1_FIRST = {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] S1_LAST  = {8'd51, 8'd50, 8'd49, 8'd35, 8'd34, 8'd33, 8'd19, 8'd18, 8'd17};
  localparam logic [71:0] S3_FIRST = {8'd166, 8'd167, 8'd168, 8'd182, 8'd183, 8'd184, 8'd198, 8'd199, 8'd200};
  localparam logic [71:0] S4_FIRST = {8'd134, 8'd133, 8'd132, 8'd118, 8'd117, 8'd116, 8'd102, 8'd101, 8'd100};
  localparam logic [71:0] S6_WIN   = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

  logic clk = 1'b0;
  logic rst;
  logic pixValid, sofIn;
  logic [DW-1:0] pixIn;
  logic [9*DW-1:0] win;
  logic winValid, frameDone;

  logic v3, s3;
  logic [DW-1:0] p3;
  logic [9*DW-1:0] win3;
  logic wv3, fd3;

  int checks = 0;
  int errors = 0;

  int img [H][W];
  int mr = 0;
  int mc = 0;
  logic [71:0] expWin;
  logic expValid, expDone;

  logic [71:0] winLog[$];
  logic        doneLog[$];
  logic [71:0] modelLog[$];
  logic [71:0] s1Log[$];

  int w3Count = 0;
  int fd3Count = 0;
  logic [71:0] w3Last = '0;
  logic w3Done = 1'b0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  median_window_3x3 #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pixValid), .pix_in(pixIn), .sof(sofIn),
    .win(win), .win_valid(winValid), .frame_done(frameDone)
  );

  median_window_3x3 #(.DATA_W(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
    .clk(clk), .rst(rst), .pix_valid(v3), .pix_in(p3), .sof(s3),
    .win(win3), .win_valid(wv3), .frame_done(fd3)
  );

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference: store each pixel into a frame array at its raster position and
  // read the 3x3 neighbourhood ending at that position.
  task automatic modelStep(input logic v, input logic s, input logic [DW-1:0] p);
    if (!v) begin
      expValid = 1'b0;
      expDone  = 1'b0;
    end else begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = int'(p);
      expValid = (mr >= 2) && (mc >= 2);
      expDone  = (mr == H-1) && (mc == W-1);
      if (expValid) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            expWin[(3*i+j)*8 +: 8] = 8'(img[mr-2+i][mc-2+j]);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
  endtask

  task automatic modelReset();
    mr = 0;
    mc = 0;
    expWin = '0;
    expValid = 1'b0;
    expDone = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] p);
    pixValid = v;
    sofIn = s;
    pixIn = p;
    @(posedge clk);
    modelStep(v, s, p);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic feedFrame(input int base, input int sign, input logic useSof, input int gap);
    int val;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        val = (sign > 0) ? base + 16*r + c : base - (16*r + c);
        applyStimulus(1'b1, useSof && (r == 0) && (c == 0), 8'(val));
        if (gap > 0 && ((r*W + c) % 2 == 0)) idle(gap);
      end
    end
  endtask

  task automatic clearLogs();
    winLog.delete();
    doneLog.delete();
    modelLog.delete();
  endtask

  // Per-cycle comparison of the 4x4 instance against the model.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("win_valid", 72'(winValid), 72'(expValid));
      checkOutput("frame_done", 72'(frameDone), 72'(expDone));
      checkOutput("win", win, expWin);
      if (winValid) begin
        winLog.push_back(win);
        doneLog.push_back(frameDone);
      end
      if (expValid) modelLog.push_back(expWin);
    end
  end

  // Observe the 3x3 instance.
  always @(negedge clk) begin
    if (rst) begin
      if (wv3) begin
        w3Count++;
        w3Last = win3;
        w3Done = fd3;
      end
      if (fd3) fd3Count++;
    end
  end

  initial begin
    rst = 1'b0;
    pixValid = 1'b0;
    sofIn = 1'b0;
    pixIn = '0;
    v3 = 1'b0;
    s3 = 1'b0;
    p3 = '0;
    modelReset();
    #1;
    checkOutput("reset_win", win, 72'd0);
    checkOutput("reset_win_valid", 72'(winValid), 72'd0);
    checkOutput("reset_frame_done", 72'(frameDone), 72'd0);
    checkOutput("reset_win3", win3, 72'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Scenario 1: one plain frame.
    clearLogs();
    feedFrame(0, 1, 1'b1, 0);
    idle(3);
    checkOutput("s1_count", 72'(winLog.size()), 72'd4);
    checkOutput("s1_model_first", modelLog[0], S1_FIRST);
    checkOutput("s1_model_last", modelLog[3], S1_LAST);
    checkOutput("s1_first", winLog[0], S1_FIRST);
    checkOutput("s1_last", winLog[3], S1_LAST);
    checkOutput("s1_last_done", 72'(doneLog[3]), 72'd1);
    s1Log = winLog;

    // Scenario 2: same frame with 3-cycle gaps at every other pixel.
    clearLogs();
    feedFrame(0, 1, 1'b1, 3);
    idle(3);
    checkOutput("s2_count", 72'(winLog.size()), 72'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("s2_win%0d", i), winLog[i], s1Log[i]);

    // Scenario 3: back-to-back frames, second without sof.
    clearLogs();
    feedFrame(0, 1, 1'b1, 0);
    feedFrame(200, -1, 1'b0, 0);
    idle(3);
    checkOutput("s3_count", 72'(winLog.size()), 72'd8);
    checkOutput("s3_f2_first", winLog[4], S3_FIRST);
    checkOutput("s3_f2_done", 72'(doneLog[7]), 72'd1);

    // Scenario 4: sof in the middle of a frame at (1,2).
    clearLogs();
    for (int k = 0; k < W + 2; k++) applyStimulus(1'b1, k == 0, 8'(16*(k / W) + (k % W)));
    feedFrame(100, 1, 1'b1, 0);
    idle(3);
    checkOutput("s4_count", 72'(winLog.size()), 72'd4);
    checkOutput("s4_first", winLog[0], S4_FIRST);
    checkOutput("s4_last_done", 72'(doneLog[3]), 72'd1);

    // Scenario 5: asynchronous reset at (2,3).
    for (int k = 0; k < 2*W + 3; k++) applyStimulus(1'b1, k == 0, 8'(16*(k / W) + (k % W)));
    pixValid = 1'b1;
    sofIn = 1'b0;
    pixIn = 8'd35;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("s5_async_win_valid", 72'(winValid), 72'd0);
    checkOutput("s5_async_frame_done", 72'(frameDone), 72'd0);
    checkOutput("s5_async_win", win, 72'd0);
    modelReset();
    pixValid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    clearLogs();
    feedFrame(0, 1, 1'b0, 0);
    idle(3);
    checkOutput("s5_count", 72'(winLog.size()), 72'd4);
    checkOutput("s5_first", winLog[0], S1_FIRST);
    checkOutput("s5_last", winLog[3], S1_LAST);

    // Scenario 6: minimum 3x3 frame.
    for (int k = 0; k < 9; k++) begin
      v3 = 1'b1;
      s3 = (k == 0);
      p3 = 8'(k);
      @(negedge clk);
    end
    v3 = 1'b0;
    s3 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("s6_count", 72'(w3Count), 72'd1);
    checkOutput("s6_win", w3Last, S6_WIN);
    checkOutput("s6_done_with_win", 72'(w3Done), 72'd1);
    checkOutput("s6_done_count", 72'(fd3Count), 72'd1);

    // Scenario 7: random pixels, random gaps, occasional sof.
    for (int n = 0; n < 600; n++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 49) == 0);
      applyStimulus(v, s, 8'($urandom));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_window_3x3.md
Name: median_window_3x3

Overview:
- Upstream stage of the median filter.
- Accepts an 8-bit raster-order pixel stream and keeps the two previous image lines in line buffers.
- Emits a full 3x3 neighbourhood, nine pixels in parallel, for every interior pixel position.
- The output feeds the compare-swap sorting network directly; the network takes nine unsigned pixels and produces the median.

Parameters:
- DATA_W, 8, pixel width in bits (unsigned).
- IMG_WIDTH, 640, pixels per line. Legal range >= 3.
- IMG_HEIGHT, 480, lines per frame. Legal range >= 3.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- pix_valid  input  1  pix_in carries a pixel this cycle.
- pix_in  input  DATA_W  unsigned pixel, raster order.
- sof  input  1  start of frame; qualified by pix_valid.
- win  output  9*DATA_W  3x3 window. Slot k sits at win[k*DATA_W +: DATA_W], with k = 3*row + col.
- win_valid  output  1  win holds a new window this cycle (single-cycle pulse per window).
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst = 0, asynchronous):
  - col/row counters go to 0; win = 0; win_valid = 0; frame_done = 0.
  - The 3x3 shift registers clear to 0.
  - Line-buffer contents are not reset. They are never exposed while row < 2.
- Reset mid-frame: the next accepted pixel is (0,0). Any partial frame is discarded and no window from it is emitted.
- Accepted pixel: a cycle with pix_valid = 1. Cycles with pix_valid = 0 hold all state, and win_valid/frame_done are 0 in them.
- Position counters (col, row):
  - col increments per accepted pixel and wraps IMG_WIDTH-1 -> 0, which increments row.
  - row wraps IMG_HEIGHT-1 -> 0. The next frame then starts automatically, with no sof needed.
- sof: when pix_valid & sof, that pixel is forced to position (0,0) whatever the counters hold, and counting resumes from it. sof without pix_valid is ignored.
- Line buffers:
  - Two buffers, each IMG_WIDTH x DATA_W, addressed by col.
  - On an accepted pixel, LB1[col] is read (line r-1) and LB0[col] is read (line r-2).
  - In the same cycle LB1[col] <= pix_in and LB0[col] <= old LB1[col]. Reads return pre-write data.
  - Reads and writes are combinational/registered inside the same cycle; there is no extra read latency.
- Window shift: on each accepted pixel, each of the three rows shifts one column left.
  - Row 0 takes LB0[col] (oldest line).
  - Row 1 takes LB1[col].
  - Row 2 takes pix_in.
  - Col 2 is the newest column, so slot 8 = current pix_in and slot 0 = pixel (r-2, c-2).
- Output:
  - win_valid is asserted the cycle after an accepted pixel at position (r, c) with r >= 2 and c >= 2.
  - Latency is 1 cycle from input pixel to window.
  - The window centre is pixel (r-1, c-1).
  - Border pixels get no window. Per frame exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows are produced.
- Column wrap: the stale columns left over from the previous line are flushed by the c >= 2 gate, so no window spans two lines.
- win holds its last value while win_valid = 0.
- frame_done:
  - Asserted the cycle after the accepted pixel at (IMG_HEIGHT-1, IMG_WIDTH-1).
  - It coincides with the final win_valid of the frame.
- Back-to-back frames: no bubble required. Row 0 of frame N+1 may follow the last pixel of frame N directly.

Decomposition:
- Shared package median_pkg holds:
  - the DATA_W default;
  - the window slot constants WIN_TL = 0 … WIN_C = 4 … WIN_BR = 8, which the sorting network also uses.
- One sub-module, median_line_buffer: parameterised depth/width, read-before-write, one read and one write port at the same address. It is instantiated twice.
- Counters, the shift matrix and the output registers stay in the top level.

Test Plan:
1. Params W = 4, H = 4; feed pixel = 16*r + c continuously, with sof on the first pixel.
   - Expect exactly 4 windows.
   - First window (after pixel (2,2)) = {0,1,2,16,17,18,32,33,34} in slots 0..8.
   - Last window = {17,18,19,33,34,35,49,50,51}, with frame_done high in the same cycle.
2. Same frame, with pix_valid deasserted for 3 cycles at every other pixel.
   - Identical window sequence to scenario 1.
   - win_valid never asserted during gaps; win held.
3. Two frames back-to-back, second frame pixel = 200 - (16*r + c), no sof on the second frame.
   - 8 windows in total.
   - The second frame's first window contains no first-frame values.
4. sof asserted with pix_valid at mid-frame position (1,2).
   - No window until row 2 col 2 of the new frame.
   - The new first window contains only post-sof pixels.
5. rst pulsed low for 2 cycles at position (2,3), asynchronous to the clock edge.
   - win_valid, frame_done and win drop to 0 immediately.
   - After release the next frame produces exactly 4 correct windows.
6. W = 3, H = 3 minimum size, pixel values 0..8.
   - Exactly one window {0..8}, with frame_done in the same cycle.
